// File: rtl/param_datapath_pkg.sv
// ---------------------------------------------------------------------------
// param_datapath_pkg
//   Shared definitions for the parametrised CPU datapath: ALU operation
//   codes, PC update (JSM) codes, ANS source select codes, flag bit
//   positions inside the {Z,C,N,V} flags word, and the MUL sequencer states.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package param_datapath_pkg;

  // ALU operation select; codes 13-15 behave as PASS A.
  typedef enum logic [3:0] {
    ALU_PASS = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_INC  = 4'd6,
    ALU_DEC  = 4'd7,
    ALU_SHL  = 4'd8,
    ALU_SHR  = 4'd9,
    ALU_ADC  = 4'd10,
    ALU_SBB  = 4'd11,
    ALU_MUL  = 4'd12
  } alu_mode_e;

  // PC update select when PCload is asserted.
  typedef enum logic [1:0] {
    JSM_NEXT = 2'd0,
    JSM_JUMP = 2'd1,
    JSM_JZ   = 2'd2,
    JSM_JC   = 2'd3
  } jsm_e;

  // ANS source select when ANSload is asserted.
  typedef enum logic [1:0] {
    SEL_ALU        = 2'd0,
    SEL_INPUT_A    = 2'd1,
    SEL_IR_OPERAND = 2'd2,
    SEL_HOLD       = 2'd3
  } sel_e;

  // Bit positions inside the {Z,C,N,V} flags word.
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // Multiplier sequencer states.
  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

  // Assemble a flags word from individual flag bits.
  function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                            input logic n, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/param_datapath_alu.sv
// ---------------------------------------------------------------------------
// param_alu
//   Purely combinational ALU with flag generation.
//   Ports:
//     a, b      in  DATA_W  operands (registered A and B)
//     mode      in  4       operation select (alu_mode_e)
//     carry_in  in  1       current C flag, used by ADC and SBB
//     result    out DATA_W  truncated result
//     flags     out 4       {Z,C,N,V} for the result
//   C is carry-out for ADD/ADC/INC, NOT borrow for SUB/SBB/DEC, and the bit
//   shifted out for SHL/SHR. V is signed overflow for the add/sub class.
//   MUL (12) is sequenced in the datapath top; here it behaves as PASS A.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module param_alu
  import param_datapath_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        mode,
  input  logic              carry_in,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  localparam int MSB = DATA_W - 1;
  localparam logic [DATA_W:0] ONE_X = (DATA_W+1)'(1);

  logic [DATA_W:0] wide;      // result with one extra bit for carry/borrow
  logic [DATA_W:0] a_x;
  logic [DATA_W:0] b_x;
  logic [DATA_W:0] cin_x;
  logic            c_flag;
  logic            v_flag;
  logic            add_class;
  logic            sub_class;
  logic            opnd_msb;  // sign of the second operand for overflow

  assign a_x   = {1'b0, a};
  assign b_x   = {1'b0, b};
  assign cin_x = {{DATA_W{1'b0}}, carry_in};

  always_comb begin
    // NOTE: every signal written here gets a default first so no branch can
    // leave one unassigned and infer a latch.
    wide      = a_x;
    c_flag    = 1'b0;
    add_class = 1'b0;
    sub_class = 1'b0;
    opnd_msb  = b[MSB];

    case (alu_mode_e'(mode))
      ALU_ADD: begin
        wide      = a_x + b_x;
        c_flag    = wide[DATA_W];
        add_class = 1'b1;
      end
      ALU_ADC: begin
        wide      = a_x + b_x + cin_x;
        c_flag    = wide[DATA_W];
        add_class = 1'b1;
      end
      ALU_INC: begin
        wide      = a_x + ONE_X;
        c_flag    = wide[DATA_W];
        add_class = 1'b1;
        opnd_msb  = 1'b0;
      end
      // For subtraction the extra bit is the borrow; C reports its inverse.
      ALU_SUB: begin
        wide      = a_x - b_x;
        c_flag    = ~wide[DATA_W];
        sub_class = 1'b1;
      end
      ALU_SBB: begin
        wide      = a_x - b_x - cin_x;
        c_flag    = ~wide[DATA_W];
        sub_class = 1'b1;
      end
      ALU_DEC: begin
        wide      = a_x - ONE_X;
        c_flag    = ~wide[DATA_W];
        sub_class = 1'b1;
        opnd_msb  = 1'b0;
      end
      ALU_AND: wide = {1'b0, a & b};
      ALU_OR:  wide = {1'b0, a | b};
      ALU_XOR: wide = {1'b0, a ^ b};
      ALU_SHL: begin
        wide   = {1'b0, a[MSB-1:0], 1'b0};
        c_flag = a[MSB];
      end
      ALU_SHR: begin
        wide   = {2'b00, a[MSB:1]};
        c_flag = a[0];
      end
      default: wide = a_x;
    endcase

    result = wide[DATA_W-1:0];

    // Signed overflow: like-signed add or unlike-signed subtract whose
    // result sign differs from A.
    v_flag = 1'b0;
    if (add_class) begin
      v_flag = (a[MSB] == opnd_msb) && (result[MSB] != a[MSB]);
    end else if (sub_class) begin
      v_flag = (a[MSB] != opnd_msb) && (result[MSB] != a[MSB]);
    end

    flags = pack_flags(result == '0, c_flag, result[MSB], v_flag);
  end

endmodule

// File: rtl/param_datapath.sv
// ---------------------------------------------------------------------------
// param_datapath
//   Parametrised CPU datapath: A/B operand registers, ALU, ANS accumulator,
//   flags register, instruction register, program counter with conditional
//   jumps, and a shift-add multiplier (one multiplier bit per cycle).
//   Ports:
//     Clk, Reset          rising-edge clock, async active-high reset
//     InputA, InputB      operand sources for A and B
//     Aload, Bload        load A / B
//     mode                ALU operation select (12 starts MUL)
//     IRload, PCload      load IR from Instr / update PC per JSM
//     ANSload             load ANS per select_mode
//     JSM                 0 PC+1, 1 jump, 2 jump if Z, 3 jump if C
//     select_mode         ANS source: 0 ALU, 1 InputA, 2 IR operand, 3 hold
//     Instr               instruction word {opcode, operand}
//     PC, IRCU            program counter / IR opcode field
//     Flags               {Z,C,N,V}
//     Busy, MulHi         MUL in progress / upper half of last product
//     Output              ANS register
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module param_datapath
  import param_datapath_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4,
  parameter int OPC_W  = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_W-1:0]     InputA,
  input  logic [DATA_W-1:0]     InputB,
  input  logic                  Aload,
  input  logic                  Bload,
  input  logic [3:0]            mode,
  input  logic                  IRload,
  input  logic                  PCload,
  input  logic                  ANSload,
  input  logic [1:0]            JSM,
  input  logic [1:0]            select_mode,
  input  logic [OPC_W+PC_W-1:0] Instr,
  output logic [PC_W-1:0]       PC,
  output logic [OPC_W-1:0]      IRCU,
  output logic [3:0]            Flags,
  output logic                  Busy,
  output logic [DATA_W-1:0]     MulHi,
  output logic [DATA_W-1:0]     Output
);

  localparam int IR_W  = OPC_W + PC_W;
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] ans_q, ans_d;
  logic [DATA_W-1:0] mulhi_q, mulhi_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [3:0]        flags_q, flags_d;
  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [DATA_W-1:0] mplier_q, mplier_d; // multiplier, shifted right each step
  logic [PROD_W-1:0] acc_q, acc_d;       // partial product

  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;
  logic [PC_W-1:0]   ir_operand;
  logic [PC_W-1:0]   pc_inc;
  logic [PROD_W-1:0] acc_next;

  assign ir_operand = ir_q[PC_W-1:0];
  assign pc_inc     = pc_q + PC_W'(1);

  param_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a        (a_q),
    .b        (b_q),
    .mode     (mode),
    .carry_in (flags_q[FLAG_C]),
    .result   (alu_result),
    .flags    (alu_flags)
  );

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    ans_d    = ans_q;
    mulhi_d  = mulhi_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    flags_d  = flags_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Operand loads stay live during MUL; the multiplier works on its own
    // captured copies.
    if (Aload)  a_d  = InputA;
    if (Bload)  b_d  = InputB;
    if (IRload) ir_d = Instr;

    // Jump conditions see the flags from before this edge.
    if (PCload) begin
      case (jsm_e'(JSM))
        JSM_NEXT: pc_d = pc_inc;
        JSM_JUMP: pc_d = ir_operand;
        JSM_JZ:   pc_d = flags_q[FLAG_Z] ? ir_operand : pc_inc;
        JSM_JC:   pc_d = flags_q[FLAG_C] ? ir_operand : pc_inc;
        default:  pc_d = pc_inc;
      endcase
    end

    case (state_q)
      MUL_IDLE: begin
        if (ANSload) begin
          case (sel_e'(select_mode))
            SEL_ALU: begin
              if (alu_mode_e'(mode) == ALU_MUL) begin
                state_d  = MUL_RUN;
                cnt_d    = '0;
                mcand_d  = {{DATA_W{1'b0}}, a_q};
                mplier_d = b_q;
                acc_d    = '0;
              end else begin
                ans_d   = alu_result;
                flags_d = alu_flags;
              end
            end
            SEL_INPUT_A:    ans_d = InputA;
            SEL_IR_OPERAND: ans_d = DATA_W'(ir_operand);
            default:        ans_d = ans_q;
          endcase
        end
      end

      // ANSload is ignored here; the product lands on the last step.
      MUL_RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = MUL_IDLE;
          ans_d   = acc_next[DATA_W-1:0];
          mulhi_d = acc_next[PROD_W-1:DATA_W];
          flags_d = pack_flags(acc_next[DATA_W-1:0] == '0, 1'b0,
                               acc_next[DATA_W-1], 1'b0);
        end
      end

      default: state_d = MUL_IDLE;
    endcase
  end

  // NOTE: every register, including the multiplier's working copies, is
  // cleared on reset so an aborted MUL leaves nothing behind to resume.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_q      <= '0;
      b_q      <= '0;
      ans_q    <= '0;
      mulhi_q  <= '0;
      ir_q     <= '0;
      pc_q     <= '0;
      flags_q  <= '0;
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before the edge, whatever order these lines appear in.
      a_q      <= a_d;
      b_q      <= b_d;
      ans_q    <= ans_d;
      mulhi_q  <= mulhi_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign Output = ans_q;
  assign MulHi  = mulhi_q;
  assign Flags  = flags_q;
  assign PC     = pc_q;
  assign IRCU   = ir_q[IR_W-1:PC_W];
  assign Busy   = (state_q == MUL_RUN);

endmodule
